seg7_capture: RTL

Receive-side monitor for the 7-segment display bus: samples the seven segment lines driven toward Segment2, filters them for stability, decodes the settled glyph back to a hex nibble and flags blank or illegal patterns. It sits on the board-loopback and debug path, fed from the PMOD header or the internal segment register. It lets a bench or a second board check the nibble-to-segment encoder end to end.

---
 rtl/seg7_capture.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seg7_capture.sv
// seg7_capture: synchronizes, debounces and decodes a 7-segment bus back to a hex nibble,
// flagging blank and illegal glyphs. Define SEG7_CAPTURE_COUNT_EN to build the change counter.
module seg7_capture #(
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter bit          ACTIVE_LOW    = 1'b1
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Nibble,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Error,
  output logic [7:0] o_Change_Count
);
  localparam int unsigned   CW      = $clog2(STABLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    EMPTY  = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t        state;
  logic [6:0]    sync1, sync2, s, cand, committed;
  logic [CW-1:0] cnt;
  logic          stable, accept, is_hex;
  logic [3:0]    hex_val;

  // Internal polarity: 1 = segment lit.
  assign s      = ACTIVE_LOW ? ~sync2 : sync2;
  assign stable = (s == cand) && (cnt == CNT_MAX);
  assign accept = stable && ((state == EMPTY) || (cand != committed));

  // Glyph table, bit order GFEDCBA.
  always_comb begin
    is_hex  = 1'b1;
    hex_val = 4'h0;
    case (cand)
      7'h3F: hex_val = 4'h0;
      7'h06: hex_val = 4'h1;
      7'h5B: hex_val = 4'h2;
      7'h4F: hex_val = 4'h3;
      7'h66: hex_val = 4'h4;
      7'h6D: hex_val = 4'h5;
      7'h7D: hex_val = 4'h6;
      7'h07: hex_val = 4'h7;
      7'h7F: hex_val = 4'h8;
      7'h6F: hex_val = 4'h9;
      7'h77: hex_val = 4'hA;
      7'h7C: hex_val = 4'hB;
      7'h39: hex_val = 4'hC;
      7'h5E: hex_val = 4'hD;
      7'h79: hex_val = 4'hE;
      7'h71: hex_val = 4'hF;
      default: is_hex = 1'b0;
    endcase
  end

  // o_Valid is a one-cycle strobe with no ready: o_Nibble is valid on the strobe
  // and holds until the next accepted hex glyph; o_Blank/o_Error are levels.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1     <= 7'd0;
      sync2     <= 7'd0;
      cand      <= 7'd0;
      cnt       <= '0;
      committed <= 7'd0;
      state     <= EMPTY;
      o_Nibble  <= 4'h0;
      o_Valid   <= 1'b0;
      o_Blank   <= 1'b0;
      o_Error   <= 1'b0;
    end else begin
      sync1   <= i_Segments;
      sync2   <= sync1;
      o_Valid <= 1'b0;

      if (s != cand) begin
        cand <= s;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end

      case (state)
        EMPTY:   if (accept) state <= HOLD;
        HOLD:    if (s != cand) state <= SETTLE;
        // Stable in SETTLE is either a new accept or a return to the committed glyph.
        SETTLE:  if (stable) state <= HOLD;
        default: state <= EMPTY;
      endcase

      if (accept) begin
        committed <= cand;
        if (cand == 7'h00) begin
          o_Blank <= 1'b1;
          o_Error <= 1'b0;
        end else if (is_hex) begin
          o_Nibble <= hex_val;
          o_Valid  <= 1'b1;
          o_Blank  <= 1'b0;
          o_Error  <= 1'b0;
        end else begin
          o_Blank <= 1'b0;
          o_Error <= 1'b1;
        end
      end
    end
  end

`ifdef SEG7_CAPTURE_COUNT_EN
  logic [7:0] change_count;

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      change_count <= 8'd0;
    end else if (accept) begin
      change_count <= change_count + 8'd1;
    end
  end

  assign o_Change_Count = change_count;
`else
  assign o_Change_Count = 8'd0;
`endif

endmodule
